// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the architectural HI/LO registers.
// Operands are processed as magnitudes; signs are restored in a single FIX cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Start,
  input  logic [1:0]            i_Op,
  input  logic [DATA_WIDTH-1:0] i_SrcA,
  input  logic [DATA_WIDTH-1:0] i_SrcB,
  input  logic                  i_Abort,
  input  logic                  i_MtHi,
  input  logic                  i_MtLo,
  input  logic [DATA_WIDTH-1:0] i_WData,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_HI,
  output logic [DATA_WIDTH-1:0] o_LO
);

  // Handshake: i_Start is taken only when o_Busy=0 and i_Abort=0; the result
  // is committed to HI/LO on the edge that raises o_Done for one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  localparam logic [CNT_WIDTH-1:0] LastStep = CNT_WIDTH'(DATA_WIDTH - 1);

  stateT                   state;
  stateT                   nextState;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [DATA_WIDTH-1:0]   hiAcc;
  logic [DATA_WIDTH-1:0]   loAcc;
  logic [DATA_WIDTH-1:0]   operand;
  logic                    isDiv;
  logic                    negRes;
  logic                    negRem;
  logic                    divZero;
  logic [DATA_WIDTH-1:0]   hiReg;
  logic [DATA_WIDTH-1:0]   loReg;
  logic                    doneReg;

  logic                    startGo;
  logic                    srcSigned;
  logic                    negA;
  logic                    negB;
  logic [DATA_WIDTH-1:0]   magA;
  logic [DATA_WIDTH-1:0]   magB;
  logic [DATA_WIDTH:0]     mulSum;
  logic [DATA_WIDTH:0]     divShift;
  logic [DATA_WIDTH:0]     divDiff;
  logic [DATA_WIDTH-1:0]   stepHi;
  logic [DATA_WIDTH-1:0]   stepLo;
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   fixHi;
  logic [DATA_WIDTH-1:0]   fixLo;

  assign startGo   = (state == IDLE) && i_Start && !i_Abort;
  assign srcSigned = ~i_Op[0];
  assign negA      = srcSigned & i_SrcA[DATA_WIDTH-1];
  assign negB      = srcSigned & i_SrcB[DATA_WIDTH-1];
  assign magA      = negA ? -i_SrcA : i_SrcA;
  assign magB      = negB ? -i_SrcB : i_SrcB;

  always_ff @(posedge i_CLK) begin
    if (i_RST) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (i_Start && !i_Abort) nextState = RUN;
      RUN: begin
        if (i_Abort)              nextState = IDLE;
        else if (cnt == LastStep) nextState = FIX;
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One iteration: multiply shifts {hiAcc,loAcc} right while adding the
  // multiplicand; divide shifts left and keeps the trial subtraction if no borrow.
  always_comb begin
    mulSum   = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, operand} : '0);
    divShift = {hiAcc, loAcc[DATA_WIDTH-1]};
    divDiff  = divShift - {1'b0, operand};
    stepHi   = hiAcc;
    stepLo   = loAcc;
    if (isDiv) begin
      if (!divDiff[DATA_WIDTH]) begin
        stepHi = divDiff[DATA_WIDTH-1:0];
        stepLo = {loAcc[DATA_WIDTH-2:0], 1'b1};
      end else begin
        stepHi = divShift[DATA_WIDTH-1:0];
        stepLo = {loAcc[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      stepHi = mulSum[DATA_WIDTH:1];
      stepLo = {mulSum[0], loAcc[DATA_WIDTH-1:1]};
    end
  end

  // Divide by zero leaves remainder = |dividend|, which the remainder sign
  // fix turns back into the dividend; only the quotient needs overriding.
  always_comb begin
    product = negRes ? -{hiAcc, loAcc} : {hiAcc, loAcc};
    fixHi   = product[2*DATA_WIDTH-1:DATA_WIDTH];
    fixLo   = product[DATA_WIDTH-1:0];
    if (isDiv) begin
      fixHi = negRem ? -hiAcc : hiAcc;
      fixLo = divZero ? '1 : (negRes ? -loAcc : loAcc);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      cnt     <= '0;
      hiAcc   <= '0;
      loAcc   <= '0;
      operand <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (startGo) begin
            cnt     <= '0;
            hiAcc   <= '0;
            isDiv   <= i_Op[1];
            negRes  <= negA ^ negB;
            negRem  <= negA;
            divZero <= (i_SrcB == '0);
            loAcc   <= i_Op[1] ? magA : magB;
            operand <= i_Op[1] ? magB : magA;
          end else if (!i_Start) begin
            if (i_MtHi) hiReg <= i_WData;
            if (i_MtLo) loReg <= i_WData;
          end
        end
        RUN: begin
          if (!i_Abort) begin
            hiAcc <= stepHi;
            loAcc <= stepLo;
            cnt   <= cnt + CNT_WIDTH'(1);
          end
        end
        FIX: begin
          if (!i_Abort) begin
            hiReg   <= fixHi;
            loReg   <= fixLo;
            doneReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Busy = (state != IDLE);
  assign o_Done = doneReg;
  assign o_HI   = hiReg;
  assign o_LO   = loReg;

endmodule
